// File: rtl/trig_capture_wr.sv
// Write-side controller for a circular waveform capture buffer.
// Streams samples into the sample RAM while armed, freezes after the post-trigger count.
module trig_capture_wr #(
   parameter int P_NBITS_ADDR = 8,
   parameter int P_NBITS_DATA = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [P_NBITS_DATA-1:0] din,
   input  logic                    din_valid,
   input  logic                    arm,
   input  logic                    trig,
   input  logic [P_NBITS_ADDR-1:0] n_post,
   input  logic                    ack,
   output logic [P_NBITS_DATA-1:0] ram_d,
   output logic [P_NBITS_ADDR-1:0] ram_addr,
   output logic                    ram_we,
   output logic                    armed,
   output logic                    done,
   output logic                    ring_full,
   output logic [P_NBITS_ADDR-1:0] trig_addr,
   output logic [P_NBITS_ADDR-1:0] oldest_addr
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [P_NBITS_ADDR-1:0] ADDR_ZERO = '0;
   localparam logic [P_NBITS_ADDR-1:0] ADDR_ONE  = {{(P_NBITS_ADDR-1){1'b0}}, 1'b1};
   localparam logic [P_NBITS_ADDR-1:0] ADDR_LAST = '1;

   state_t                  state_reg,      state_next;
   logic [P_NBITS_ADDR-1:0] wr_ptr_reg,     wr_ptr_next;
   logic [P_NBITS_ADDR-1:0] post_cnt_reg,   post_cnt_next;
   logic [P_NBITS_ADDR-1:0] n_post_lat_reg, n_post_lat_next;
   logic [P_NBITS_ADDR-1:0] trig_addr_reg,  trig_addr_next;
   logic                    ring_full_reg,  ring_full_next;
   logic [P_NBITS_DATA-1:0] ram_d_reg,      ram_d_next;
   logic [P_NBITS_ADDR-1:0] ram_addr_reg,   ram_addr_next;
   logic                    ram_we_reg,     ram_we_next;
   logic                    wr_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         wr_ptr_reg     <= '0;
         post_cnt_reg   <= '0;
         n_post_lat_reg <= '0;
         trig_addr_reg  <= '0;
         ring_full_reg  <= 1'b0;
         ram_d_reg      <= '0;
         ram_addr_reg   <= '0;
         ram_we_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wr_ptr_reg     <= wr_ptr_next;
         post_cnt_reg   <= post_cnt_next;
         n_post_lat_reg <= n_post_lat_next;
         trig_addr_reg  <= trig_addr_next;
         ring_full_reg  <= ring_full_next;
         ram_d_reg      <= ram_d_next;
         ram_addr_reg   <= ram_addr_next;
         ram_we_reg     <= ram_we_next;
      end
   end

   // Samples are only accepted while a capture is in progress.
   assign wr_en = din_valid && ((state_reg == S_ARMED) || (state_reg == S_POST));

   always_comb begin
      state_next      = state_reg;
      wr_ptr_next     = wr_ptr_reg;
      post_cnt_next   = post_cnt_reg;
      n_post_lat_next = n_post_lat_reg;
      trig_addr_next  = trig_addr_reg;
      ring_full_next  = ring_full_reg;
      ram_d_next      = ram_d_reg;
      ram_addr_next   = ram_addr_reg;
      ram_we_next     = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (arm) begin
               state_next      = S_ARMED;
               wr_ptr_next     = ADDR_ZERO;
               ring_full_next  = 1'b0;
               n_post_lat_next = n_post;
            end
         end
         S_ARMED: begin
            if (din_valid && trig) begin
               trig_addr_next = wr_ptr_reg;
               post_cnt_next  = n_post_lat_reg;
               state_next     = (n_post_lat_reg == ADDR_ZERO) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            // post_cnt is never zero here: a zero count goes straight to DONE.
            if (din_valid) begin
               post_cnt_next = post_cnt_reg - ADDR_ONE;
               if (post_cnt_reg == ADDR_ONE) begin
                  state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (ack) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if (wr_en) begin
         ram_we_next   = 1'b1;
         ram_addr_next = wr_ptr_reg;
         ram_d_next    = din;
         wr_ptr_next   = wr_ptr_reg + ADDR_ONE;
         if (wr_ptr_reg == ADDR_LAST) begin
            ring_full_next = 1'b1;
         end
      end
   end

   assign ram_d     = ram_d_reg;
   assign ram_addr  = ram_addr_reg;
   assign ram_we    = ram_we_reg;
   assign armed     = (state_reg == S_ARMED) || (state_reg == S_POST);
   assign done      = (state_reg == S_DONE);
   assign ring_full = ring_full_reg;
   assign trig_addr = trig_addr_reg;

   // Until the ring has wrapped the oldest sample is at address 0.
   generate
      for (genvar gi = 0; gi < P_NBITS_ADDR; gi++) begin : g_oldest
         assign oldest_addr[gi] = ring_full_reg & wr_ptr_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_trig_capture_wr.sv
// Directed bench for trig_capture_wr: vector table plus wrap and reset sequences.
module tb_trig_capture_wr;

   logic        clk;
   logic        rst_n;
   logic [13:0] din;
   logic        din_valid;
   logic        arm;
   logic        trig;
   logic [7:0]  n_post;
   logic        ack;
   logic [13:0] ram_d;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic        armed;
   logic        done;
   logic        ring_full;
   logic [7:0]  trig_addr;
   logic [7:0]  oldest_addr;

   int total = 0;
   int bad   = 0;

   trig_capture_wr #(.P_NBITS_ADDR(8), .P_NBITS_DATA(14)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .arm        (arm),
      .trig       (trig),
      .n_post     (n_post),
      .ack        (ack),
      .ram_d      (ram_d),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .armed      (armed),
      .done       (done),
      .ring_full  (ring_full),
      .trig_addr  (trig_addr),
      .oldest_addr(oldest_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        arm;
      logic        trig;
      logic        dv;
      logic        ack;
      logic [7:0]  np;
      logic [13:0] din;
      logic        we;
      logic [7:0]  addr;
      logic [13:0] d;
      logic        armed;
      logic        done;
      logic        full;
      logic [7:0]  taddr;
      logic [7:0]  oaddr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic a, input logic t, input logic v, input logic k,
                      input logic [7:0] np, input logic [13:0] di,
                      input logic we, input logic [7:0] ad, input logic [13:0] d,
                      input logic ar, input logic dn, input logic fl,
                      input logic [7:0] ta, input logic [7:0] oa);
      vec_t x;
      x.arm = a; x.trig = t; x.dv = v; x.ack = k; x.np = np; x.din = di;
      x.we = we; x.addr = ad; x.d = d; x.armed = ar; x.done = dn; x.full = fl;
      x.taddr = ta; x.oaddr = oa;
      vq.push_back(x);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at negedge, then sample 1 time unit after posedge.
   task automatic step(input logic a, input logic t, input logic v, input logic k,
                       input logic [7:0] np, input logic [13:0] di);
      @(negedge clk);
      arm = a; trig = t; din_valid = v; ack = k; n_post = np; din = di;
      @(posedge clk);
      #1;
   endtask

   // Full output snapshot; address/data only matter on a write cycle.
   function automatic logic [63:0] snap(input logic we_m);
      return {22'd0, ram_we, armed, done, ring_full, trig_addr, oldest_addr,
              (we_m ? ram_addr : 8'd0), (we_m ? ram_d : 14'd0)};
   endfunction

   function automatic logic [63:0] want(input vec_t x);
      return {22'd0, x.we, x.armed, x.done, x.full, x.taddr, x.oaddr,
              (x.we ? x.addr : 8'd0), (x.we ? x.d : 14'd0)};
   endfunction

   initial begin
      rst_n = 1'b0; din = '0; din_valid = 0; arm = 0; trig = 0; n_post = '0; ack = 0;

      // arm n_post=3, trigger on 5th sample
      add(1,0,0,0, 8'd3, 14'h000, 0,8'd0,14'h0, 1,0,0, 8'd0,8'd0);
      for (int i = 0; i < 8; i++)
         add(0,(i==4),1,0, 8'd0, 14'h100+14'(i), 1,8'(i),14'h100+14'(i),
             (i!=7),(i==7),0, (i>=4) ? 8'd4 : 8'd0, 8'd0);
      add(0,0,0,0, 8'd0, 14'h000, 0,8'd0,14'h0, 0,1,0, 8'd4,8'd0);
      add(0,0,0,1, 8'd0, 14'h000, 0,8'd0,14'h0, 0,0,0, 8'd4,8'd0);
      // n_post=0, trigger on first sample
      add(1,0,0,0, 8'd0, 14'h000, 0,8'd0,14'h0,   1,0,0, 8'd4,8'd0);
      add(0,1,1,0, 8'd0, 14'h2AA, 1,8'd0,14'h2AA, 0,1,0, 8'd0,8'd0);
      add(0,0,1,0, 8'd0, 14'h2AB, 0,8'd0,14'h0,   0,1,0, 8'd0,8'd0);
      add(0,0,0,1, 8'd0, 14'h000, 0,8'd0,14'h0,   0,0,0, 8'd0,8'd0);
      // valid toggling, trig on invalid cycle ignored, arm/ack/trig ignored later
      add(1,0,0,0, 8'd2, 14'h000, 0,8'd0,14'h0,   1,0,0, 8'd0,8'd0);
      add(0,0,1,0, 8'd0, 14'h010, 1,8'd0,14'h010, 1,0,0, 8'd0,8'd0);
      add(0,1,0,0, 8'd0, 14'h3FF, 0,8'd0,14'h0,   1,0,0, 8'd0,8'd0);
      add(0,0,1,0, 8'd0, 14'h011, 1,8'd1,14'h011, 1,0,0, 8'd0,8'd0);
      add(0,0,0,0, 8'd0, 14'h000, 0,8'd0,14'h0,   1,0,0, 8'd0,8'd0);
      add(0,1,1,0, 8'd0, 14'h012, 1,8'd2,14'h012, 1,0,0, 8'd2,8'd0);
      add(1,0,1,0, 8'd9, 14'h013, 1,8'd3,14'h013, 1,0,0, 8'd2,8'd0);
      add(0,0,1,1, 8'd0, 14'h014, 1,8'd4,14'h014, 0,1,0, 8'd2,8'd0);
      add(0,1,1,0, 8'd0, 14'h015, 0,8'd0,14'h0,   0,1,0, 8'd2,8'd0);
      add(1,0,0,1, 8'd7, 14'h000, 0,8'd0,14'h0,   0,0,0, 8'd2,8'd0);
      add(0,0,1,0, 8'd0, 14'h016, 0,8'd0,14'h0,   0,0,0, 8'd2,8'd0);

      // reset state, sampled while reset is held
      #12;
      chk("reset", snap(1'b1), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         step(vq[i].arm, vq[i].trig, vq[i].dv, vq[i].ack, vq[i].np, vq[i].din);
         $display("vec %0d: we=%0b addr=%0d d=%h armed=%0b done=%0b trig_addr=%0d",
                  i, ram_we, ram_addr, ram_d, armed, done, trig_addr);
         chk($sformatf("vec%0d", i), snap(vq[i].we), want(vq[i]));
      end

      // wrap: 300 samples, then trigger with n_post=10
      step(1,0,0,0, 8'd10, 14'h0);
      for (int i = 0; i < 300; i++) begin
         step(0,0,1,0, 8'd0, 14'(i));
         chk($sformatf("wrap%0d", i), {47'd0, ram_we, ram_addr, ram_d},
             {47'd0, 1'b1, 8'(i % 256), 14'(i)});
         if (i == 254 || i == 255)
            chk($sformatf("full_at%0d", i), {63'd0, ring_full}, {63'd0, (i == 255)});
      end
      step(0,1,1,0, 8'd0, 14'h3000);
      $display("wrap trig: addr=%0d trig_addr=%0d", ram_addr, trig_addr);
      chk("wrap_trig", {47'd0, ram_we, ram_addr, trig_addr, armed, 5'd0},
          {47'd0, 1'b1, 8'd44, 8'd44, 1'b1, 5'd0});
      for (int j = 0; j < 10; j++) begin
         step(0,0,1,0, 8'd0, 14'h3001 + 14'(j));
         chk($sformatf("wrap_post%0d", j), {55'd0, ram_we, ram_addr},
             {55'd0, 1'b1, 8'(45 + j)});
      end
      chk("wrap_done_rise", {62'd0, done, armed}, {62'd0, 1'b1, 1'b0});
      step(0,0,1,0, 8'd0, 14'h0);
      $display("wrap done: trig_addr=%0d oldest=%0d full=%0b", trig_addr, oldest_addr, ring_full);
      chk("wrap_final", {44'd0, ram_we, done, ring_full, trig_addr, oldest_addr, 1'b0},
          {44'd0, 1'b0, 1'b1, 1'b1, 8'd44, 8'd55, 1'b0});
      step(0,0,0,1, 8'd0, 14'h0);
      chk("wrap_ack", {62'd0, done, armed}, 64'd0);

      // reset mid-POST
      step(1,0,0,0, 8'd5, 14'h0);
      for (int i = 0; i < 3; i++) step(0,0,1,0, 8'd0, 14'h50 + 14'(i));
      step(0,1,1,0, 8'd0, 14'h53);
      step(0,0,1,0, 8'd0, 14'h54);
      chk("pre_rst", {55'd0, armed, ram_addr}, {55'd0, 1'b1, 8'd4});
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      $display("async reset: we=%0b armed=%0b trig_addr=%0d", ram_we, armed, trig_addr);
      chk("rst_async", snap(1'b1), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_hold", snap(1'b1), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step(0,1,1,0, 8'd0, 14'h60);
         chk($sformatf("post_rst_idle%0d", i), {62'd0, ram_we, armed}, 64'd0);
      end
      step(1,0,0,0, 8'd1, 14'h0);
      step(0,0,1,0, 8'd0, 14'h77);
      $display("rearm: we=%0b addr=%0d d=%h", ram_we, ram_addr, ram_d);
      chk("rearm", {40'd0, ram_we, armed, ram_addr, ram_d},
          {40'd0, 1'b1, 1'b1, 8'd0, 14'h77});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trig_capture_wr.md
Name: trig_capture_wr

Overview:
- Write-side controller for a waveform capture buffer.
- Streams ADC samples into a dual-port sample RAM as a circular buffer while armed.
- On trigger, records a fixed number of post-trigger samples, then freezes the buffer and flags it for readout.
- Sits directly upstream of the sample RAM write port; the readout engine consumes `done`, `trig_addr` and `oldest_addr`.

Parameters:
- P_NBITS_ADDR, 8, RAM address width; ring depth = 2^P_NBITS_ADDR.
- P_NBITS_DATA, 14, sample width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  P_NBITS_DATA  ADC sample.
- din_valid  in  1  din valid this cycle.
- arm  in  1  single-cycle pulse; starts a capture from IDLE.
- trig  in  1  trigger; qualified by din_valid.
- n_post  in  P_NBITS_ADDR  post-trigger sample count; latched on arm.
- ack  in  1  readout finished; releases buffer.
- ram_d  out  P_NBITS_DATA  RAM write data.
- ram_addr  out  P_NBITS_ADDR  RAM write address.
- ram_we  out  1  RAM write enable.
- armed  out  1  high in ARMED or POST.
- done  out  1  high in DONE.
- ring_full  out  1  at least 2^P_NBITS_ADDR samples written since arm.
- trig_addr  out  P_NBITS_ADDR  address holding the trigger sample.
- oldest_addr  out  P_NBITS_ADDR  first address to read: wr_ptr if ring_full, else 0.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; wr_ptr, post_cnt and n_post_lat = 0.
  - All outputs 0.
- Outputs ram_d, ram_addr and ram_we are registered: a sample accepted on cycle k appears on the RAM port in cycle k+1.
- ram_we is high for exactly one cycle per write.
- Write rule:
  - A sample is written when `din_valid` = 1 in ARMED or POST.
  - ram_addr = wr_ptr, then wr_ptr increments.
  - wr_ptr wraps from 2^N-1 to 0 with no stall.
- IDLE:
  - No writes.
  - arm = 1 → ARMED; wr_ptr = 0, ring_full = 0, n_post_lat = n_post.
  - trig and ack are ignored.
- ARMED:
  - Writes every valid sample.
  - ring_full sets when wr_ptr wraps to 0 and stays set until the next arm.
  - trig = 1 and din_valid = 1 on the same cycle:
    - That sample is written.
    - trig_addr = current wr_ptr.
    - post_cnt = n_post_lat.
    - If n_post_lat == 0 → DONE, else → POST.
  - trig with din_valid = 0 is ignored.
- POST:
  - Each valid sample is written and decrements post_cnt.
  - The write that takes post_cnt from 1 to 0 → DONE.
  - Exactly n_post_lat samples follow the trigger sample. n_post = 2^N-1 fills the ring so the trigger sample is the oldest.
  - trig is ignored.
- DONE:
  - No writes.
  - done = 1; trig_addr and oldest_addr are held stable.
  - ack = 1 → IDLE; done drops next cycle.
- Ignored inputs:
  - arm in ARMED, POST or DONE is ignored; no restart mid-capture.
  - ack outside DONE is ignored.
- armed = 1 in ARMED and POST.
- oldest_addr:
  - Combinational from the registered wr_ptr and ring_full.
  - Meaningful in DONE; undefined content addresses are the reader's responsibility when ring_full = 0.
- Reset asserted mid-capture returns to IDLE immediately. RAM contents are untouched; this block does not clear memory.
- Simultaneous events:
  - arm and ack together in DONE → IDLE only.
  - The arm must be re-issued.

Test Plan:
- Reset, arm with n_post=3, din_valid=1, din counting from 0x100, trig on the 5th sample (addr 4) → writes addr 0..7, trig_addr=4, done rises the cycle after the addr-7 write is accepted, ring_full=0, oldest_addr=0.
- N=8, arm, stream 300 samples, then trig, n_post=10 → wr_ptr wraps, ring_full=1, trig_addr=(300 mod 256)=44, last write addr 54, oldest_addr=55.
- n_post=0, trig on first sample → single write at addr 0, DONE next cycle; then ack → IDLE, armed=0, done=0.
- din_valid toggling 1,0,1,0 with trig asserted only on an invalid cycle → no trigger taken; trig on the next valid cycle → trig_addr equals that sample's address; no ram_we on invalid cycles.
- arm pulsed during POST and trig pulsed during DONE → no effect on state, pointers or trig_addr; ack before DONE → ignored.
- rst_n low for 1 cycle mid-POST → all outputs 0 asynchronously, state IDLE, no further ram_we; a fresh arm restarts at addr 0.
